// File: rtl/board_pkg.sv
// Shared board geometry, mode encoding and engine state type.
package board_pkg;

   localparam int BOARD_COLS = 10;
   localparam int BOARD_ROWS = 24;
   localparam int CELL_W     = 6;

   localparam logic MODE_FILL     = 1'b0;
   localparam logic MODE_COLLAPSE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_RD,
      ST_WR,
      ST_TOP,
      ST_DONE
   } state_e;

endpackage

// File: rtl/board_ram_engine_if.sv
// Board RAM write/read port; the engine is master, the RAM is slave.
interface board_ram_engine_if
   import board_pkg::*;
#(
   parameter int DATA_W = CELL_W,
   parameter int ADDR_W = 8
);

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      output ram_addr,
      output ram_wren,
      output ram_wdata,
      input  ram_rdata
   );

   modport slave (
      input  ram_addr,
      input  ram_wren,
      input  ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/board_ram_engine_cell_walker.sv
// Row/col walker with an incrementally maintained cell address.
// Ascending walks step the address by +1; descending walks jump back one
// row at each column wrap so the address always tracks (row-1)*COLS + col.
module cell_walker #(
   parameter int COLS   = 10,
   parameter int ROW_W  = 5,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              load_down,
   input  logic [ROW_W-1:0]  load_row,
   input  logic [ROW_W-1:0]  load_last_row,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] addr_nxt,
   output logic              last
);

   localparam int                COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] ROW_BACK = ADDR_W'(2 * COLS - 1);

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ROW_W-1:0]  last_row_q, last_row_d;
   logic              down_q, down_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              col_wrap;

   assign col_wrap = (col_q == COL_LAST);

   // Load a new walk or advance one cell.
   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      last_row_d = last_row_q;
      down_d     = down_q;
      addr_d     = addr_q;
      if (load) begin
         col_d      = '0;
         row_d      = load_row;
         last_row_d = load_last_row;
         down_d     = load_down;
         addr_d     = load_addr;
      end else if (step) begin
         if (col_wrap) begin
            col_d  = '0;
            row_d  = down_q ? row_q - 1'b1 : row_q + 1'b1;
            addr_d = down_q ? addr_q - ROW_BACK : addr_q + 1'b1;
         end else begin
            col_d  = col_q + 1'b1;
            addr_d = addr_q + 1'b1;
         end
      end
   end

   // Walker state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q      <= '0;
         row_q      <= '0;
         last_row_q <= '0;
         down_q     <= 1'b0;
         addr_q     <= '0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         last_row_q <= last_row_d;
         down_q     <= down_d;
         addr_q     <= addr_d;
      end
   end

   assign addr     = addr_q;
   assign addr_nxt = addr_d;
   assign last     = col_wrap && (row_q == last_row_q);

endmodule

// File: rtl/board_ram_engine.sv
// Board RAM maintenance engine: whole-board fill or single-row collapse.
module board_ram_engine
   import board_pkg::*;
#(
   parameter int COLS   = BOARD_COLS,
   parameter int ROWS   = BOARD_ROWS,
   parameter int DATA_W = CELL_W,
   parameter int ADDR_W = 8,
   parameter int ROW_W  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic [DATA_W-1:0]  fill_value,
   input  logic [ROW_W-1:0]   row_sel,
   board_ram_engine_if.master ram,
   output logic               busy,
   output logic               done
);

   localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
   localparam logic [ROW_W-1:0]  LAST_ROW_FILL = ROW_W'(ROWS - 1);
   localparam logic [ROW_W:0]    ROWS_R        = (ROW_W + 1)'(ROWS);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wren_q, wren_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] fill_q, fill_d;

   logic              w_load, w_down, w_step, w_last;
   logic [ROW_W-1:0]  w_load_row, w_last_row;
   logic [ADDR_W-1:0] w_load_addr, w_addr, w_addr_nxt;
   logic              row_valid;

   assign row_valid = ({1'b0, row_sel} < ROWS_R);

   cell_walker #(
      .COLS   (COLS),
      .ROW_W  (ROW_W),
      .ADDR_W (ADDR_W)
   ) u_walker (
      .clk           (clk),
      .reset         (reset),
      .load          (w_load),
      .load_down     (w_down),
      .load_row      (w_load_row),
      .load_last_row (w_last_row),
      .load_addr     (w_load_addr),
      .step          (w_step),
      .addr          (w_addr),
      .addr_nxt      (w_addr_nxt),
      .last          (w_last)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) begin
            if (mode == MODE_FILL)  state_d = ST_FILL;
            else if (row_sel == '0) state_d = ST_TOP;
            else if (row_valid)     state_d = ST_RD;
            else                    state_d = ST_DONE;
         end
         ST_FILL: if (w_last) state_d = ST_DONE;
         ST_RD:   state_d = ST_WR;
         ST_WR:   state_d = w_last ? ST_TOP : ST_RD;
         ST_TOP:  if (w_last) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Walker control: the only multiply is row_sel*COLS at collapse start.
   always_comb begin
      w_load      = 1'b0;
      w_down      = 1'b0;
      w_step      = 1'b0;
      w_load_row  = '0;
      w_last_row  = '0;
      w_load_addr = '0;
      case (state_q)
         ST_IDLE: if (start) begin
            if (mode == MODE_FILL) begin
               w_load     = 1'b1;
               w_last_row = LAST_ROW_FILL;
            end else if (row_sel == '0) begin
               w_load = 1'b1;
            end else if (row_valid) begin
               w_load      = 1'b1;
               w_down      = 1'b1;
               w_load_row  = row_sel;
               w_last_row  = ROW_W'(1);
               w_load_addr = ADDR_W'(row_sel) * COLS_A - COLS_A;
            end
         end
         ST_FILL, ST_TOP: w_step = !w_last;
         ST_WR: begin
            if (w_last) w_load = 1'b1;
            else        w_step = 1'b1;
         end
         default: ;
      endcase
   end

   // Output decode keyed on the next state so every port comes from a flop.
   always_comb begin
      addr_d  = addr_q;
      wren_d  = 1'b0;
      wdata_d = wdata_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      fill_d  = fill_q;
      if (state_q == ST_IDLE && start) fill_d = fill_value;
      case (state_d)
         ST_FILL, ST_TOP: begin
            addr_d  = w_addr_nxt;
            wren_d  = 1'b1;
            wdata_d = fill_d;
            busy_d  = 1'b1;
         end
         ST_RD: begin
            addr_d = w_addr_nxt;
            busy_d = 1'b1;
         end
         ST_WR: begin
            addr_d = w_addr + COLS_A;
            wren_d = 1'b1;
            busy_d = 1'b1;
         end
         ST_DONE: done_d = 1'b1;
         default: ;
      endcase
   end

   // Output and latched-operand registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wren_q  <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fill_q  <= '0;
      end else begin
         addr_q  <= addr_d;
         wren_q  <= wren_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fill_q  <= fill_d;
      end
   end

   // Read data only arrives during WR, so the copy path bypasses the
   // wdata flop there; the RAM's own output register sources it.
   assign ram.ram_addr  = addr_q;
   assign ram.ram_wren  = wren_q;
   assign ram.ram_wdata = (state_q == ST_WR) ? ram.ram_rdata : wdata_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_board_ram_engine.sv
// Testbench for board_ram_engine: RAM model, write scoreboard, vector table.
module tb_board_ram_engine;
   import board_pkg::*;

   localparam int NCELL    = BOARD_ROWS * BOARD_COLS;
   localparam int PRE_RAND = 0;
   localparam int PRE_ROW  = 1;

   typedef struct {
      logic        mode;
      logic [4:0]  row_sel;
      logic [5:0]  fill;
      int unsigned pre;
      int unsigned lat;
      int unsigned busy_n;
      int unsigned writes;
   } vec_t;

   typedef struct {
      logic [7:0] addr;
      logic [5:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [5:0]  fill_value = '0;
   logic [4:0]  row_sel = '0;
   logic        busy, done;

   int unsigned n_vec = 0;
   int unsigned n_fail = 0;
   int unsigned wr_cnt = 0;
   logic        load_req = 1'b0;
   logic [5:0]  mem     [256];
   logic [5:0]  pre_img [256];
   logic [5:0]  model   [256];
   wr_t         exp_q [$];
   vec_t        vecs [8];

   board_ram_engine_if #(.DATA_W(6), .ADDR_W(8)) ram_if ();

   board_ram_engine #(
      .COLS   (10),
      .ROWS   (24),
      .DATA_W (6),
      .ADDR_W (8),
      .ROW_W  (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .fill_value (fill_value),
      .row_sel    (row_sel),
      .ram        (ram_if),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Synchronous RAM: registered read data, one cycle after the address.
   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 256; i++) mem[i] <= pre_img[i];
      end else if (ram_if.ram_wren) begin
         mem[ram_if.ram_addr] <= ram_if.ram_wdata;
      end
      ram_if.ram_rdata <= mem[ram_if.ram_addr];
   end

   // Scoreboard: every presented write must match the next expected one.
   always @(negedge clk) begin
      wr_t e;
      if (ram_if.ram_wren) begin
         wr_cnt <= wr_cnt + 1;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data %0h, required no write",
                     ram_if.ram_addr, ram_if.ram_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(ram_if.ram_addr), 64'(e.addr));
            chk("wr_data", 64'(ram_if.ram_wdata), 64'(e.data));
         end
      end
   end

   task automatic preload(input int unsigned kind);
      for (int a = 0; a < 256; a++)
         pre_img[a] = (kind == PRE_ROW && a < NCELL) ? 6'(a / BOARD_COLS)
                                                     : 6'($urandom_range(0, 63));
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   // Reference behaviour straight from the operation description.
   task automatic build_expect(input logic m, input logic [4:0] rs, input logic [5:0] fv);
      wr_t w;
      for (int a = 0; a < 256; a++) model[a] = pre_img[a];
      if (m == MODE_FILL) begin
         for (int a = 0; a < NCELL; a++) begin
            w.addr = 8'(a); w.data = fv; exp_q.push_back(w); model[a] = fv;
         end
      end else if (int'(rs) < BOARD_ROWS) begin
         for (int r = int'(rs); r >= 1; r--) begin
            for (int c = 0; c < BOARD_COLS; c++) begin
               int src, dst;
               src = (r - 1) * BOARD_COLS + c;
               dst = src + BOARD_COLS;
               w.addr = 8'(dst); w.data = model[src]; exp_q.push_back(w);
               model[dst] = model[src];
            end
         end
         for (int c = 0; c < BOARD_COLS; c++) begin
            w.addr = 8'(c); w.data = fv; exp_q.push_back(w); model[c] = fv;
         end
      end
   endtask

   task automatic check_ram(input string name);
      int unsigned bad = 0;
      for (int a = 0; a < NCELL; a++) if (mem[a] !== model[a]) bad++;
      chk(name, 64'(bad), 64'd0);
   endtask

   task automatic run_op(input logic m, input logic [4:0] rs, input logic [5:0] fv,
                         output int unsigned lat, output int unsigned bcnt);
      mode = m; row_sel = rs; fill_value = fv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < 2000) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int unsigned lat, bcnt, base, k, dn_mask, dn_cnt;

      vecs[0] = '{1'b0, 5'd0,  6'h00, PRE_RAND, 241, 240, 240};
      vecs[1] = '{1'b1, 5'd23, 6'h00, PRE_ROW,  471, 470, 240};
      vecs[2] = '{1'b1, 5'd0,  6'h2A, PRE_RAND, 11,  10,  10};
      vecs[3] = '{1'b1, 5'd24, 6'h05, PRE_RAND, 1,   0,   0};
      vecs[4] = '{1'b1, 5'd1,  6'h3F, PRE_ROW,  31,  30,  20};
      vecs[5] = '{1'b0, 5'd0,  6'h15, PRE_RAND, 241, 240, 240};
      vecs[6] = '{1'b1, 5'd31, 6'h11, PRE_RAND, 1,   0,   0};
      vecs[7] = '{1'b1, 5'd12, 6'h07, PRE_RAND, 251, 250, 130};

      repeat (3) @(negedge clk);
      chk("reset_state", 64'({ram_if.ram_addr, ram_if.ram_wren, ram_if.ram_wdata, busy, done}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         preload(vecs[i].pre);
         exp_q.delete();
         build_expect(vecs[i].mode, vecs[i].row_sel, vecs[i].fill);
         base = wr_cnt;
         run_op(vecs[i].mode, vecs[i].row_sel, vecs[i].fill, lat, bcnt);
         chk($sformatf("v%0d_done_latency", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].busy_n));
         chk($sformatf("v%0d_done_busy_wren", i), 64'({busy, ram_if.ram_wren}), 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d_done_width", i), 64'(done), 64'd0);
         #1;
         chk($sformatf("v%0d_write_count", i), 64'(wr_cnt - base), 64'(vecs[i].writes));
         chk($sformatf("v%0d_queue_left", i), 64'(exp_q.size()), 64'd0);
         check_ram($sformatf("v%0d_ram_cells", i));
         if (i == 1) begin
            chk("v1_row23_holds_22", 64'(mem[235]), 64'd22);
            chk("v1_row1_holds_0", 64'(mem[14]), 64'd0);
         end
         @(negedge clk);
      end

      // start during busy and in the DONE cycle is ignored; next IDLE start accepted
      preload(PRE_RAND);
      exp_q.delete();
      build_expect(1'b1, 5'd0, 6'h33);
      base = wr_cnt;
      dn_mask = 0;
      mode = 1'b1; row_sel = 5'd0; fill_value = 6'h33; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (k = 1; k <= 16; k++) begin
         if (done) dn_mask |= (1 << k);
         if (k == 3)  begin start = 1'b1; mode = 1'b0; end
         if (k == 4)  start = 1'b0;
         if (k == 11) begin start = 1'b1; mode = 1'b0; end
         if (k == 12) begin mode = 1'b1; row_sel = 5'd24; end
         if (k == 13) start = 1'b0;
         @(negedge clk);
      end
      #1;
      chk("ignore_start_done_cycles", 64'(dn_mask), 64'((1 << 11) | (1 << 13)));
      chk("ignore_start_write_count", 64'(wr_cnt - base), 64'd10);
      chk("ignore_start_queue_left", 64'(exp_q.size()), 64'd0);
      check_ram("ignore_start_ram_cells");

      // reset mid-FILL after 100 committed writes
      preload(PRE_RAND);
      exp_q.delete();
      for (int a = 0; a < 256; a++) model[a] = pre_img[a];
      for (int a = 0; a <= 100; a++) begin
         wr_t w;
         w.addr = 8'(a); w.data = 6'h2C; exp_q.push_back(w);
         if (a < 100) model[a] = 6'h2C;
      end
      base = wr_cnt;
      mode = 1'b0; fill_value = 6'h2C; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      k = 0;
      while ((wr_cnt - base) < 101 && k < 400) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("midreset_reached_101st", 64'(wr_cnt - base), 64'd101);
      reset = 1'b1;
      #1;
      chk("midreset_async_clear",
          64'({ram_if.ram_addr, ram_if.ram_wren, ram_if.ram_wdata, busy, done}), 64'd0);
      dn_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) dn_cnt++;
      end
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) dn_cnt++;
      end
      #1;
      chk("midreset_no_done", 64'(dn_cnt), 64'd0);
      chk("midreset_write_count", 64'(wr_cnt - base), 64'd101);
      chk("midreset_queue_left", 64'(exp_q.size()), 64'd0);
      check_ram("midreset_ram_cells");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
      $fatal(1, "timeout");
   end

endmodule
